prg_rom_responder: RTL

- ROM-side responder for the cartridge PRG ROM on the NES side.
- Accepts the program-ROM requests issued by the NIOS-facing ROM programmer (ROM_ADDR/TO_ROM/READ_ROM/WRITE_ROM) and returns read data on FROM_ROM with an acknowledge.
- Also serves NES CPU instruction/data fetches in $8000-$FFFF, arbitrating both requesters onto one synchronous on-chip RAM with 1-cycle read latency.

---
 rtl/prg_rom_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prg_rom_responder.sv
// PRG ROM responder: arbitrates the NIOS ROM programmer and NES CPU fetches
// onto one synchronous RAM with 1-cycle read latency.
module prg_rom_responder #(
    parameter int          PRG_BANKS = 2,
    parameter int          MEM_AW    = 15,
    parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PRGM_EN,
    input  logic [15:0]       ROM_ADDR,
    input  logic [7:0]        TO_ROM,
    input  logic              READ_ROM,
    input  logic              WRITE_ROM,
    output logic [7:0]        FROM_ROM,
    output logic              PRGM_ACK,
    input  logic [15:0]       CPU_ADDR,
    input  logic              CPU_RD,
    output logic [7:0]        CPU_DATA,
    output logic              CPU_VALID,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [7:0]        MEM_RDATA
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE} state_t;

    state_t      state;
    logic        owner_cpu;

    logic        p_pend;
    logic        p_wr;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    logic        c_pend;
    logic [15:0] c_addr;

    // Out-of-range/blocked completions are deferred one cycle to keep the
    // 2-cycle latency; grants are held off while one is outstanding.
    logic        ob_p;
    logic        ob_p_rd;
    logic        ob_c;

    logic        gnt_p;
    logic        gnt_c;

    function automatic logic [MEM_AW-1:0] map_addr(input logic [15:0] a);
        logic [14:0] m;
        m = {(PRG_BANKS == 2) ? a[14] : 1'b0, a[13:0]};
        return MEM_AW'(m);
    endfunction

    always_comb begin
        gnt_p = 1'b0;
        gnt_c = 1'b0;
        if (state == IDLE && !ob_p && !ob_c) begin
            if (p_pend && (!c_pend || PRGM_EN))
                gnt_p = 1'b1;
            else if (c_pend)
                gnt_c = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            owner_cpu <= 1'b0;
            p_pend    <= 1'b0;
            p_wr      <= 1'b0;
            p_addr    <= '0;
            p_data    <= '0;
            c_pend    <= 1'b0;
            c_addr    <= '0;
            ob_p      <= 1'b0;
            ob_p_rd   <= 1'b0;
            ob_c      <= 1'b0;
            FROM_ROM  <= '0;
            PRGM_ACK  <= 1'b0;
            CPU_DATA  <= '0;
            CPU_VALID <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_WE    <= 1'b0;
            MEM_RE    <= 1'b0;
        end else begin
            PRGM_ACK  <= 1'b0;
            CPU_VALID <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_RE    <= 1'b0;
            ob_p      <= 1'b0;
            ob_c      <= 1'b0;

            if (ob_p) begin
                PRGM_ACK <= 1'b1;
                if (ob_p_rd)
                    FROM_ROM <= OPEN_BUS;
            end
            if (ob_c) begin
                CPU_VALID <= 1'b1;
                CPU_DATA  <= OPEN_BUS;
            end

            // Request capture; write wins over a simultaneous read.
            if ((READ_ROM || WRITE_ROM) && (!p_pend || gnt_p)) begin
                p_pend <= 1'b1;
                p_wr   <= WRITE_ROM;
                p_addr <= ROM_ADDR;
                p_data <= TO_ROM;
            end else if (gnt_p) begin
                p_pend <= 1'b0;
            end

            if (CPU_RD && (!c_pend || gnt_c)) begin
                c_pend <= 1'b1;
                c_addr <= CPU_ADDR;
            end else if (gnt_c) begin
                c_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (gnt_p) begin
                        if (p_addr[15]) begin
                            MEM_ADDR  <= map_addr(p_addr);
                            owner_cpu <= 1'b0;
                            if (p_wr) begin
                                MEM_WE    <= 1'b1;
                                MEM_WDATA <= p_data;
                                state     <= WR_ISSUE;
                            end else begin
                                MEM_RE <= 1'b1;
                                state  <= RD_ISSUE;
                            end
                        end else begin
                            ob_p    <= 1'b1;
                            ob_p_rd <= !p_wr;
                        end
                    end else if (gnt_c) begin
                        if (c_addr[15] && !PRGM_EN) begin
                            MEM_ADDR  <= map_addr(c_addr);
                            MEM_RE    <= 1'b1;
                            owner_cpu <= 1'b1;
                            state     <= RD_ISSUE;
                        end else begin
                            ob_c <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: state <= RD_CAPTURE;
                RD_CAPTURE: begin
                    if (owner_cpu) begin
                        CPU_DATA  <= MEM_RDATA;
                        CPU_VALID <= 1'b1;
                    end else begin
                        FROM_ROM <= MEM_RDATA;
                        PRGM_ACK <= 1'b1;
                    end
                    state <= IDLE;
                end
                WR_ISSUE: begin
                    PRGM_ACK <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
